// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin two-requester controller for a single-port synchronous RAM
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD1  = 2'd2,
    RD2  = 2'd3
  } state_t;

  state_t                state;
  logic                  owner_b;   // 0: current access belongs to A, 1: to B
  logic                  rr_b;      // 1: B wins the next contention, 0: A wins
  logic                  drive_en;  // registered bus drive enable, high only in WR
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  sel_valid;
  logic                  sel_b;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // The RAM bus is only ever driven from a flop, never from a request input.
  assign mem_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

  assign sel_valid = a_req | b_req;
  assign sel_we    = sel_b ? b_we    : a_we;
  assign sel_addr  = sel_b ? b_addr  : a_addr;
  assign sel_wdata = sel_b ? b_wdata : a_wdata;

  // Pick the winner: a lone requester wins, contention goes to the pointer.
  always_comb begin
    sel_b = 1'b0;
    if (a_req && b_req) begin
      sel_b = rr_b;
    end else if (b_req) begin
      sel_b = 1'b1;
    end
  end

  // Access sequencer: all RAM strobes, grants and returns are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner_b  <= 1'b0;
      rr_b     <= 1'b0;
      drive_en <= 1'b0;
      wdata_q  <= '0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      mem_addr <= '0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_oe   <= 1'b0;
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            owner_b  <= sel_b;
            rr_b     <= ~sel_b;
            mem_addr <= sel_addr;
            wdata_q  <= sel_wdata;
            a_gnt    <= ~sel_b;
            b_gnt    <= sel_b;
            mem_cs   <= 1'b1;
            if (sel_we) begin
              state    <= WR;
              mem_we   <= 1'b1;
              drive_en <= 1'b1;
            end else begin
              state    <= RD1;
            end
          end
        end
        WR: begin
          // The RAM commits on the edge that leaves this state.
          state    <= IDLE;
          mem_cs   <= 1'b0;
          mem_we   <= 1'b0;
          drive_en <= 1'b0;
        end
        RD1: begin
          // The RAM registers mem[addr] on this edge; open its output next.
          state  <= RD2;
          mem_oe <= 1'b1;
        end
        RD2: begin
          state  <= IDLE;
          mem_cs <= 1'b0;
          mem_oe <= 1'b0;
          if (owner_b) begin
            b_rdata  <= mem_data;
            b_rvalid <= 1'b1;
          end else begin
            a_rdata  <= mem_data;
            a_rvalid <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          mem_cs   <= 1'b0;
          mem_we   <= 1'b0;
          mem_oe   <= 1'b0;
          drive_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_cs, mem_we, mem_oe;
  wire  [DW-1:0] mem_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_data(mem_data)
  );

  // Single-port synchronous RAM with registered read and tristate output
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : {DW{1'bz}};
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_data;
      else        ram_q <= ram[mem_addr];
    end
  end

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Reference model: transaction timeline plus memory image
  logic [DW-1:0] mmem [0:(1<<AW)-1];
  logic          s_valid, s_we, last_b, rv_b;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, exp_a_rdata, exp_b_rdata;
  int            s_at, free_at, rv_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
  endtask

  task automatic model_reset();
    s_valid = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    s_at = -10; free_at = 0; rv_at = -1; rv_b = 1'b0;
    last_b = 1'b1;
    exp_a_rdata = '0; exp_b_rdata = '0;
  endtask

  task automatic set_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d;
  endtask

  task automatic set_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d;
  endtask

  // One clock: predict from the inputs seen at the edge, then compare all outputs.
  task automatic step();
    logic pick_b, e_ag, e_bg, e_av, e_bv, e_cs, e_we, e_oe;
    logic [DW-1:0] e_md;
    @(posedge clk);
    cyc++;
    e_ag = 1'b0; e_bg = 1'b0; e_av = 1'b0; e_bv = 1'b0;
    if (s_valid && s_we && cyc == s_at + 1) mmem[s_addr] = s_wdata;
    if (cyc >= free_at && (a_req || b_req)) begin
      pick_b  = (a_req && b_req) ? ~last_b : b_req;
      last_b  = pick_b;
      s_valid = 1'b1;
      s_at    = cyc;
      s_we    = pick_b ? b_we : a_we;
      s_addr  = pick_b ? b_addr : a_addr;
      s_wdata = pick_b ? b_wdata : a_wdata;
      free_at = cyc + (s_we ? 2 : 3);
      if (!s_we) begin rv_at = cyc + 2; rv_b = pick_b; end
      e_ag = ~pick_b; e_bg = pick_b;
    end
    #1;
    if (rv_at == cyc) begin
      if (rv_b) begin e_bv = 1'b1; exp_b_rdata = mmem[s_addr]; end
      else      begin e_av = 1'b1; exp_a_rdata = mmem[s_addr]; end
    end
    e_cs = s_valid && cyc >= s_at && cyc < free_at - 1;
    e_we = e_cs && s_we;
    e_oe = e_cs && !s_we && cyc == s_at + 1;
    e_md = e_we ? s_wdata : (e_oe ? mmem[s_addr] : {DW{1'bz}});
    chk("a_gnt", 32'(a_gnt), 32'(e_ag));
    chk("b_gnt", 32'(b_gnt), 32'(e_bg));
    chk("a_rvalid", 32'(a_rvalid), 32'(e_av));
    chk("b_rvalid", 32'(b_rvalid), 32'(e_bv));
    chk("a_rdata", 32'(a_rdata), 32'(exp_a_rdata));
    chk("b_rdata", 32'(b_rdata), 32'(exp_b_rdata));
    chk("mem_cs", 32'(mem_cs), 32'(e_cs));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_oe", 32'(mem_oe), 32'(e_oe));
    chk("mem_addr", 32'(mem_addr), 32'(s_addr));
    chk("mem_data", 32'(mem_data), 32'(e_md));
    if (e_ag) a_req = 1'b0;
    if (e_bg) b_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((a_req || b_req || cyc + 1 < free_at || rv_at > cyc) && n < 40) begin
      step();
      n++;
    end
    chk("drain_bound", 32'(n < 40), 32'h1);
  endtask

  // Assert reset mid-cycle, check the cleared outputs, hold, release after an edge.
  task automatic do_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_gnt", 32'(a_gnt), 32'h0);
    chk("rst_b_gnt", 32'(b_gnt), 32'h0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'h0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'h0);
    chk("rst_a_rdata", 32'(a_rdata), 32'h0);
    chk("rst_b_rdata", 32'(b_rdata), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_cs", 32'(mem_cs), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_oe", 32'(mem_oe), 32'h0);
    chk("rst_mem_data", 32'(mem_data), 32'({DW{1'bz}}));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("rst_hold_rvalid", 32'({a_rvalid, b_rvalid}), 32'h0);
      chk("rst_hold_gnt", 32'({a_gnt, b_gnt}), 32'h0);
      chk("rst_hold_cs", 32'(mem_cs), 32'h0);
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    int order [4];
    int n, prev;
    logic b_seen;
    logic [DW-1:0] b_first, d;

    model_reset();

    // Reset with both requesting; the first grant after release goes to A
    set_a(1'b1, 4'd2, 16'h00A2);
    set_b(1'b1, 4'd1, 16'h00B1);
    do_reset(2);
    step();
    chk("t1_first_a_gnt", 32'(a_gnt), 32'h1);
    chk("t1_first_b_gnt", 32'(b_gnt), 32'h0);
    drain();

    // A writes 8001 to addr 3 then reads it back
    set_a(1'b1, 4'd3, 16'h8001);
    step();
    chk("t2_wr_gnt", 32'(a_gnt), 32'h1);
    set_a(1'b0, 4'd3, 16'h0000);
    step();
    step();
    chk("t2_rd_gnt", 32'(a_gnt), 32'h1);
    step();
    step();
    chk("t2_rvalid", 32'(a_rvalid), 32'h1);
    chk("t2_rdata", 32'(a_rdata), 32'h8001);
    chk("t2_b_rdata", 32'(b_rdata), 32'h0);

    // Continuous contention after reset: A writes addr 5, B reads addr 5
    do_reset(1);
    b_seen = 1'b0; b_first = '0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin
        if (!a_req) set_a(1'b1, 4'd5, 16'h1234);
        if (!b_req) set_b(1'b0, 4'd5, 16'h0000);
        step();
        n++;
        if (b_rvalid && !b_seen) begin b_seen = 1'b1; b_first = b_rdata; end
      end while (!(a_gnt || b_gnt) && n < 6);
      order[g] = a_gnt ? 1 : (b_gnt ? 2 : 0);
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("t3_order0", 32'(order[0]), 32'd1);
    chk("t3_order1", 32'(order[1]), 32'd2);
    chk("t3_order2", 32'(order[2]), 32'd1);
    chk("t3_order3", 32'(order[3]), 32'd2);
    chk("t3_b_seen", 32'(b_seen), 32'h1);
    chk("t3_b_first", 32'(b_first), 32'h1234);
    drain();

    // Boundary address 15 via B
    set_b(1'b1, 4'hF, 16'hFFFF);
    step();
    chk("t4_wr_gnt", 32'(b_gnt), 32'h1);
    chk("t4_wr_addr", 32'(mem_addr), 32'hF);
    chk("t4_wr_data", 32'(mem_data), 32'hFFFF);
    set_b(1'b0, 4'hF, 16'h0000);
    step();
    step();
    chk("t4_rd1_addr", 32'(mem_addr), 32'hF);
    step();
    chk("t4_rd2_addr", 32'(mem_addr), 32'hF);
    chk("t4_rd2_oe", 32'(mem_oe), 32'h1);
    step();
    chk("t4_rvalid", 32'(b_rvalid), 32'h1);
    chk("t4_rdata", 32'(b_rdata), 32'hFFFF);
    chk("t4_a_rdata", 32'(a_rdata), 32'h0);

    // Reset during RD2 drops the read and clears rdata; re-issue succeeds
    set_a(1'b0, 4'd3, 16'h0000);
    step(); step(); step();
    chk("t5_pre_rdata", 32'(a_rdata), 32'h8001);
    set_a(1'b0, 4'hF, 16'h0000);
    step(); step();
    chk("t5_in_rd2", 32'(mem_oe), 32'h1);
    do_reset(3);
    set_a(1'b0, 4'hF, 16'h0000);
    step(); step(); step();
    chk("t5_reissue_rvalid", 32'(a_rvalid), 32'h1);
    chk("t5_reissue_rdata", 32'(a_rdata), 32'hFFFF);

    // Back-to-back writes from A with req held: one grant every 2 cycles
    set_a(1'b1, 4'd0, 16'h0000);
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      n = 0;
      do begin step(); n++; end while (!a_gnt && n < 4);
      chk("t6_gnt_seen", 32'(a_gnt), 32'h1);
      if (i > 0) chk("t6_gap", 32'(cyc - prev), 32'd2);
      prev = cyc;
      if (i < 15) begin
        d = 16'(i + 1) * 16'h0101;
        set_a(1'b1, 4'(i + 1), d);
      end
    end
    drain();
    for (int i = 0; i < 16; i++) begin
      set_a(1'b0, 4'(i), 16'h0000);
      step(); step(); step();
      d = 16'(i) * 16'h0101;
      chk("t6_rd_rvalid", 32'(a_rvalid), 32'h1);
      chk("t6_rd_data", 32'(a_rdata), 32'(d));
    end

    // Randomized traffic from both requesters against the model
    for (int i = 0; i < 400; i++) begin
      if (!a_req && $urandom_range(0, 3) != 0)
        set_a(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
      if (!b_req && $urandom_range(0, 3) != 0)
        set_b(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
      step();
    end
    a_req = 1'b0; b_req = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
